// File: rtl/gain_ramp.sv
// gain_ramp: stereo output-gain stage with a smoothly ramped gain.
//
// On each accepted sample strobe the left/right samples and the current gain
// are latched, then multiplied one after the other on a single shared
// multiplier. Both results are presented together, held stable, with a
// one-cycle out_valid pulse. After each accepted strobe the gain moves toward
// the (mute-aware) target by at most STEP.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   sample_stb   one-cycle pulse per audio frame
//   left_in      signed left sample  (BITSIZE)
//   right_in     signed right sample (BITSIZE)
//   gain_target  requested gain, unsigned (GAINBITS), unity = 2^(GAINBITS-1)
//   mute         forces the effective target to 0
//   left_out     signed left result, held between updates
//   right_out    signed right result, held between updates
//   out_valid    one-cycle pulse when left_out/right_out update
//   gain_cur     current ramped gain
//   overrun      sticky; a strobe arrived while a frame was in progress
//
// Configuration macro:
//   GAIN_RAMP_SAT_EN  defined: clamp the scaled result to the BITSIZE range.
//                     undefined: keep the low BITSIZE bits (wrap-around).

module gain_ramp #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8,
    parameter int STEP     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_stb,
    input  logic signed [BITSIZE-1:0]  left_in,
    input  logic signed [BITSIZE-1:0]  right_in,
    input  logic        [GAINBITS-1:0] gain_target,
    input  logic                       mute,
    output logic signed [BITSIZE-1:0]  left_out,
    output logic signed [BITSIZE-1:0]  right_out,
    output logic                       out_valid,
    output logic        [GAINBITS-1:0] gain_cur,
    output logic                       overrun
);

    localparam int PW = BITSIZE + GAINBITS + 1;

    typedef enum logic [1:0] {StIdle, StMulL, StMulR, StPush} state_t;

    state_t                     state_q;
    logic signed [BITSIZE-1:0]  left_q, right_q;
    logic        [GAINBITS-1:0] gain_lat_q;
    logic signed [BITSIZE-1:0]  prod_l_q, prod_r_q;
    logic signed [BITSIZE-1:0]  left_out_q, right_out_q;
    logic                       valid_q;
    logic        [GAINBITS-1:0] gain_cur_q;
    logic                       overrun_q;

    // Shared multiplier: operand chosen by state, result narrowed combinationally.
    logic signed [BITSIZE-1:0] mul_a;
    logic signed [PW-1:0]      mul_a_ext, mul_b_ext, product, shifted;
    logic signed [BITSIZE-1:0] narrowed;

    always_comb begin
        mul_a     = (state_q == StMulR) ? right_q : left_q;
        mul_a_ext = $signed({{(GAINBITS + 1){mul_a[BITSIZE-1]}}, mul_a});
        // Gain is unsigned; a zero MSB makes it a non-negative signed operand.
        mul_b_ext = $signed({{(BITSIZE + 1){1'b0}}, gain_lat_q});
        product   = mul_a_ext * mul_b_ext;
        shifted   = product >>> (GAINBITS - 1);
    end

`ifdef GAIN_RAMP_SAT_EN
    logic signed [PW-1:0] max_val, min_val;

    always_comb begin
        max_val = $signed({{(PW - BITSIZE + 1){1'b0}}, {(BITSIZE - 1){1'b1}}});
        min_val = $signed({{(PW - BITSIZE + 1){1'b1}}, {(BITSIZE - 1){1'b0}}});
        if (shifted > max_val) begin
            narrowed = max_val[BITSIZE-1:0];
        end else if (shifted < min_val) begin
            narrowed = min_val[BITSIZE-1:0];
        end else begin
            narrowed = shifted[BITSIZE-1:0];
        end
    end
`else
    always_comb begin
        narrowed = shifted[BITSIZE-1:0];
    end
`endif

    // Ramp: step toward the effective target, landing exactly when the gap
    // is no larger than STEP so the gain can neither overshoot nor wrap.
    logic [GAINBITS-1:0] eff_target, gap, gain_next;

    always_comb begin
        eff_target = mute ? '0 : gain_target;
        gain_next  = gain_cur_q;
        gap        = '0;
        if (eff_target > gain_cur_q) begin
            gap       = eff_target - gain_cur_q;
            gain_next = (int'(gap) > STEP) ? gain_cur_q + GAINBITS'(STEP) : eff_target;
        end else if (eff_target < gain_cur_q) begin
            gap       = gain_cur_q - eff_target;
            gain_next = (int'(gap) > STEP) ? gain_cur_q - GAINBITS'(STEP) : eff_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            left_q      <= '0;
            right_q     <= '0;
            gain_lat_q  <= '0;
            prod_l_q    <= '0;
            prod_r_q    <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            valid_q     <= 1'b0;
            gain_cur_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (sample_stb && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (sample_stb) begin
                        left_q     <= left_in;
                        right_q    <= right_in;
                        gain_lat_q <= gain_cur_q;
                        gain_cur_q <= gain_next;
                        state_q    <= StMulL;
                    end
                end
                StMulL: begin
                    prod_l_q <= narrowed;
                    state_q  <= StMulR;
                end
                StMulR: begin
                    prod_r_q <= narrowed;
                    state_q  <= StPush;
                end
                StPush: begin
                    left_out_q  <= prod_l_q;
                    right_out_q <= prod_r_q;
                    valid_q     <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign out_valid = valid_q;
    assign gain_cur  = gain_cur_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gain_ramp.sv
module tb_gain_ramp;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_stb = 1'b0;
    logic signed [15:0] left_in = '0;
    logic signed [15:0] right_in = '0;
    logic        [7:0]  gain_target = '0;
    logic               mute = 1'b0;
    logic signed [15:0] left_out, right_out;
    logic               out_valid;
    logic        [7:0]  gain_cur;
    logic               overrun;

    gain_ramp dut (
        .clk         (clk),
        .reset       (reset),
        .sample_stb  (sample_stb),
        .left_in     (left_in),
        .right_in    (right_in),
        .gain_target (gain_target),
        .mute        (mute),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
        .gain_cur    (gain_cur),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int vcount = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scale a sample by gain/128, rounding toward minus infinity, then narrow.
    function automatic int scale(input int s, input int g);
        longint p, r;
        p = longint'(s) * g;
        r = (p >= 0) ? p / 128 : -((-p + 127) / 128);
`ifdef GAIN_RAMP_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`else
        r = ((r % 65536) + 65536) % 65536;
        if (r >= 32768) r = r - 65536;
`endif
        return int'(r);
    endfunction

    // Behavioural model: frame accepted if at least 4 cycles after the last
    // accepted one; results appear 3 edges later.
    int     cyc = 0;
    int     m_gain = 0, m_left = 0, m_right = 0, m_valid = 0, m_ovr = 0;
    int     pend = 0, pend_cyc = 0, pend_l = 0, pend_r = 0, free_at = 0;

    always @(posedge clk) begin
        int tgt;
        cyc++;
        if (reset) begin
            m_gain = 0; m_left = 0; m_right = 0; m_valid = 0; m_ovr = 0;
            pend = 0; free_at = 0;
        end else begin
            m_valid = 0;
            if (pend != 0 && cyc == pend_cyc) begin
                m_left = pend_l; m_right = pend_r; m_valid = 1; pend = 0;
            end
            if (sample_stb) begin
                if (cyc < free_at) begin
                    m_ovr = 1;
                end else begin
                    pend_l   = scale(int'(left_in), m_gain);
                    pend_r   = scale(int'(right_in), m_gain);
                    pend     = 1;
                    pend_cyc = cyc + 3;
                    free_at  = cyc + 4;
                    tgt = mute ? 0 : int'(gain_target);
                    if (tgt > m_gain) m_gain = (tgt - m_gain > 1) ? m_gain + 1 : tgt;
                    else if (tgt < m_gain) m_gain = (m_gain - tgt > 1) ? m_gain - 1 : tgt;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", {31'b0, out_valid}, m_valid);
            check("left_out", left_out, m_left);
            check("right_out", right_out, m_right);
            check("gain_cur", {24'b0, gain_cur}, m_gain);
            check("overrun", {31'b0, overrun}, m_ovr);
        end
    end

    always @(posedge clk) if (chk_en && out_valid === 1'b1) vcount++;

    task automatic frame(input int l, input int r);
        @(negedge clk);
        left_in = 16'(l); right_in = 16'(r); sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int vb;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_left", left_out, 0);
        check("rst_gain", {24'b0, gain_cur}, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_overrun", {31'b0, overrun}, 0);
        reset = 1'b0;

        // Fade in from 0 to unity.
        gain_target = 8'd128;
        frame(1000, -1000);
        check("first_frame_left", left_out, 0);
        check("first_frame_right", right_out, 0);
        check("first_frame_gain", {24'b0, gain_cur}, 1);
        repeat (128) frame(1000, -1000);
        check("unity_gain", {24'b0, gain_cur}, 128);
        check("unity_left", left_out, 1000);
        check("unity_right", right_out, -1000);

        // Latency: outputs change only at the third edge after the strobe edge.
        @(negedge clk);
        left_in = 16'sd500; right_in = -16'sd500; sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        check("lat_valid_n", {31'b0, out_valid}, 0);
        check("lat_left_n", left_out, 1000);
        @(negedge clk);
        check("lat_valid_n1", {31'b0, out_valid}, 0);
        @(negedge clk);
        check("lat_valid_n2", {31'b0, out_valid}, 0);
        check("lat_left_n2", left_out, 1000);
        @(negedge clk);
        check("lat_valid_n3", {31'b0, out_valid}, 1);
        check("lat_left_n3", left_out, 500);
        check("lat_right_n3", right_out, -500);
        @(negedge clk);
        check("lat_valid_n4", {31'b0, out_valid}, 0);
        check("lat_left_hold", left_out, 500);
        repeat (4) @(negedge clk);

        // Maximum gain on near-full-scale samples.
        gain_target = 8'd255;
        repeat (127) frame(30000, -30000);
        check("max_gain", {24'b0, gain_cur}, 255);
        frame(30000, -30000);
`ifdef GAIN_RAMP_SAT_EN
        check("max_left", left_out, 32767);
        check("max_right", right_out, -32768);
`else
        check("max_left", left_out, -5771);
        check("max_right", right_out, 5770);
`endif

        // Back to unity, then mute fade-out and fade-in.
        gain_target = 8'd128;
        repeat (127) frame(1000, -1000);
        check("back_unity", {24'b0, gain_cur}, 128);
        mute = 1'b1;
        frame(1000, -1000);
        check("mute_step1", {24'b0, gain_cur}, 127);
        repeat (127) frame(1000, -1000);
        check("mute_zero", {24'b0, gain_cur}, 0);
        frame(1000, -1000);
        check("mute_left", left_out, 0);
        check("mute_right", right_out, 0);
        mute = 1'b0;
        repeat (128) frame(1000, -1000);
        check("unmute_gain", {24'b0, gain_cur}, 128);

        // Overrun: two strobes two cycles apart.
        gain_target = 8'd100;
        vb = vcount;
        check("pre_overrun", {31'b0, overrun}, 0);
        @(negedge clk); sample_stb = 1'b1;
        @(negedge clk); sample_stb = 1'b0;
        @(negedge clk); sample_stb = 1'b1;
        @(negedge clk); sample_stb = 1'b0;
        repeat (8) @(negedge clk);
        check("overrun_set", {31'b0, overrun}, 1);
        check("overrun_pulses", vcount - vb, 1);
        check("overrun_gain", {24'b0, gain_cur}, 127);
        frame(1000, -1000);
        check("overrun_sticky", {31'b0, overrun}, 1);

        // Reset while the right product is being computed.
        gain_target = 8'd128;
        vb = vcount;
        @(negedge clk); sample_stb = 1'b1;
        @(negedge clk); sample_stb = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_left", left_out, 0);
        check("abort_right", right_out, 0);
        check("abort_gain", {24'b0, gain_cur}, 0);
        check("abort_overrun", {31'b0, overrun}, 0);
        repeat (4) @(negedge clk);
        check("abort_no_valid", vcount - vb, 0);
        vb = vcount;
        frame(1000, -1000);
        check("after_abort_pulse", vcount - vb, 1);
        check("after_abort_gain", {24'b0, gain_cur}, 1);
        frame(1000, -1000);
        check("after_abort_left", left_out, 7);
        check("after_abort_right", right_out, -8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
